// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ID/EX ALU control slice:
//   - alu_op_t         : 4-bit ALU operation codes understood by the EX ALU
//   - OPC_*            : RISC-V major opcodes recognised by the decoder
//   - ex_ctrl_t        : control half of the ID/EX register
//   - EX_CTRL_BUBBLE   : control value of an empty (bubble) EX slot
//   - alu_funct3_decode: funct3 -> ALU op map shared by R-type and I-ALU
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND     = 4'b0000,
        ALU_OR      = 4'b0001,
        ALU_ADD     = 4'b0010,
        ALU_SUB     = 4'b0011,
        ALU_SLL     = 4'b0100,
        ALU_SRL     = 4'b0101,
        ALU_SRA     = 4'b0111,
        ALU_EQ      = 4'b1000,
        ALU_XOR     = 4'b1010,
        ALU_SLT     = 4'b1100,
        ALU_NOP_ILL = 4'b1111    // ALU returns 0 for this code
    } alu_op_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic    valid;
        alu_op_t op;
        logic    illegal;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_CTRL_BUBBLE = '{valid: 1'b0, op: ALU_ADD, illegal: 1'b0};

    typedef struct packed {
        alu_op_t op;
        logic    illegal;
    } op_dec_t;

    // alt selects SUB/SRA; callers pass 0 where the alternate form does not exist.
    function automatic op_dec_t alu_funct3_decode(input logic [2:0] funct3,
                                                  input logic       alt);
        op_dec_t d;
        d.illegal = 1'b0;
        case (funct3)
            3'b000:  d.op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  d.op = ALU_SLL;
            3'b010:  d.op = ALU_SLT;
            3'b100:  d.op = ALU_XOR;
            3'b101:  d.op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  d.op = ALU_OR;
            3'b111:  d.op = ALU_AND;
            default: begin
                // SLTU/SLTIU: no unsigned compare in this ALU
                d.op      = ALU_NOP_ILL;
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// ---------------------------------------------------------------------------
// alu_op_decoder
// Purely combinational decode of one instruction into ALU operation code and
// operand selection.
// Ports:
//   i_instr   : raw 32-bit instruction word
//   i_pc      : instruction PC
//   i_rs1     : rs1 value (already forwarded)
//   i_rs2     : rs2 value (already forwarded)
//   i_imm     : sign-extended immediate
//   o_op      : ALU operation code
//   o_src_a   : ALU SrcA
//   o_src_b   : ALU SrcB
//   o_illegal : encoding not supported by this pipeline
// ---------------------------------------------------------------------------
module alu_op_decoder
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           i_instr,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic [DATA_WIDTH-1:0] i_rs1,
    input  logic [DATA_WIDTH-1:0] i_rs2,
    input  logic [DATA_WIDTH-1:0] i_imm,
    output alu_op_t               o_op,
    output logic [DATA_WIDTH-1:0] o_src_a,
    output logic [DATA_WIDTH-1:0] o_src_b,
    output logic                  o_illegal
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_funct7_b5;
    op_dec_t    w_r_dec;
    op_dec_t    w_i_dec;

    assign w_opcode    = i_instr[6:0];
    assign w_funct3    = i_instr[14:12];
    assign w_funct7_b5 = i_instr[30];

    // Register indices and the rest of funct7 are not needed for ALU control.
    logic w_unused_instr_bits;
    assign w_unused_instr_bits = ^{i_instr[31], i_instr[29:15], i_instr[11:7]};

    assign w_r_dec = alu_funct3_decode(w_funct3, w_funct7_b5);
    // ADDI has no subtract form, but SRAI does use funct7[5].
    assign w_i_dec = alu_funct3_decode(w_funct3,
                                       (w_funct3 == 3'b101) ? w_funct7_b5 : 1'b0);

    always_comb begin
        o_op      = ALU_NOP_ILL;
        o_src_a   = '0;
        o_src_b   = '0;
        o_illegal = 1'b1;
        case (w_opcode)
            OPC_R: begin
                o_op      = w_r_dec.op;
                o_illegal = w_r_dec.illegal;
                o_src_a   = i_rs1;
                o_src_b   = i_rs2;
            end
            OPC_I_ALU: begin
                o_op      = w_i_dec.op;
                o_illegal = w_i_dec.illegal;
                o_src_a   = i_rs1;
                o_src_b   = i_imm;
            end
            OPC_LOAD, OPC_STORE: begin
                o_op      = ALU_ADD;
                o_illegal = 1'b0;
                o_src_a   = i_rs1;
                o_src_b   = i_imm;
            end
            OPC_BRANCH: begin
                // Only the base comparison is computed; the branch unit
                // inverts it for BNE/BGE.
                o_src_a = i_rs1;
                o_src_b = i_rs2;
                case (w_funct3)
                    3'b000, 3'b001: begin
                        o_op      = ALU_EQ;
                        o_illegal = 1'b0;
                    end
                    3'b100, 3'b101: begin
                        o_op      = ALU_SLT;
                        o_illegal = 1'b0;
                    end
                    default: begin
                        // BLTU/BGEU and the reserved encodings
                        o_op      = ALU_NOP_ILL;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                o_op      = ALU_ADD;
                o_illegal = 1'b0;
                o_src_a   = '0;
                o_src_b   = i_imm;
            end
            OPC_AUIPC: begin
                o_op      = ALU_ADD;
                o_illegal = 1'b0;
                o_src_a   = i_pc;
                o_src_b   = i_imm;
            end
            OPC_JAL, OPC_JALR: begin
                // ALU produces the link address pc+4; the target is computed elsewhere.
                o_op      = ALU_ADD;
                o_illegal = 1'b0;
                o_src_a   = i_pc;
                o_src_b   = DATA_WIDTH'(4);
            end
            default: begin
                o_op      = ALU_NOP_ILL;
                o_illegal = 1'b1;
                o_src_a   = '0;
                o_src_b   = '0;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_alu_ctrl.sv
// ---------------------------------------------------------------------------
// id_ex_alu_ctrl
// ID/EX pipeline register for the ALU control and operand inputs. Decode is
// done by alu_op_decoder; this level holds the register with flush > stall >
// load priority. All outputs are registered.
// Ports:
//   clk, reset      : clock (rising edge) and asynchronous active-high reset
//   id_valid        : ID holds a real instruction
//   id_instr        : raw instruction word
//   id_pc           : instruction PC
//   id_rs1_data     : rs1 value (already forwarded)
//   id_rs2_data     : rs2 value (already forwarded)
//   id_imm          : sign-extended immediate
//   stall           : hold the ID/EX register
//   flush           : load a bubble into the ID/EX register
//   ex_valid        : EX holds a real instruction
//   ex_operation    : ALU operation code
//   ex_src_a/b      : ALU operands
//   ex_illegal      : unsupported encoding (only meaningful with ex_valid)
// ---------------------------------------------------------------------------
module id_ex_alu_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic [31:0]              id_instr,
    input  logic [DATA_WIDTH-1:0]    id_pc,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     ex_valid,
    output logic [OPCODE_LENGTH-1:0] ex_operation,
    output logic [DATA_WIDTH-1:0]    ex_src_a,
    output logic [DATA_WIDTH-1:0]    ex_src_b,
    output logic                     ex_illegal
);

    alu_op_t               w_op;
    logic [DATA_WIDTH-1:0] w_src_a;
    logic [DATA_WIDTH-1:0] w_src_b;
    logic                  w_illegal;

    logic                     r_valid;
    logic [OPCODE_LENGTH-1:0] r_op;
    logic [DATA_WIDTH-1:0]    r_src_a;
    logic [DATA_WIDTH-1:0]    r_src_b;
    logic                     r_illegal;

    alu_op_decoder #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_dec (
        .i_instr   (id_instr),
        .i_pc      (id_pc),
        .i_rs1     (id_rs1_data),
        .i_rs2     (id_rs2_data),
        .i_imm     (id_imm),
        .o_op      (w_op),
        .o_src_a   (w_src_a),
        .o_src_b   (w_src_b),
        .o_illegal (w_illegal)
    );

    // ID -> EX boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= EX_CTRL_BUBBLE.valid;
            r_op      <= OPCODE_LENGTH'(EX_CTRL_BUBBLE.op);
            r_src_a   <= '0;
            r_src_b   <= '0;
            r_illegal <= EX_CTRL_BUBBLE.illegal;
        end else if (flush || (!stall && !id_valid)) begin
            // Flush wins over stall; an empty ID slot also enters EX as a bubble.
            r_valid   <= EX_CTRL_BUBBLE.valid;
            r_op      <= OPCODE_LENGTH'(EX_CTRL_BUBBLE.op);
            r_src_a   <= '0;
            r_src_b   <= '0;
            r_illegal <= EX_CTRL_BUBBLE.illegal;
        end else if (!stall) begin
            r_valid   <= 1'b1;
            r_op      <= OPCODE_LENGTH'(w_op);
            r_src_a   <= w_src_a;
            r_src_b   <= w_src_b;
            r_illegal <= w_illegal;
        end
    end

    assign ex_valid     = r_valid;
    assign ex_operation = r_op;
    assign ex_src_a     = r_src_a;
    assign ex_src_b     = r_src_b;
    assign ex_illegal   = r_illegal;

endmodule

// File: tb/tb_id_ex_alu_ctrl.sv
module tb_id_ex_alu_ctrl;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [3:0]  ex_operation;
    logic [31:0] ex_src_a;
    logic [31:0] ex_src_b;
    logic        ex_illegal;

    int vectors;
    int miscompares;

    // {valid, op, src_a, src_b, illegal}
    logic [69:0] obs;
    assign obs = {ex_valid, ex_operation, ex_src_a, ex_src_b, ex_illegal};

    localparam logic [69:0] BUBBLE = {1'b0, 4'b0010, 32'd0, 32'd0, 1'b0};

    id_ex_alu_ctrl #(
        .DATA_WIDTH    (32),
        .OPCODE_LENGTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_rs1_data  (id_rs1_data),
        .id_rs2_data  (id_rs2_data),
        .id_imm       (id_imm),
        .stall        (stall),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_operation (ex_operation),
        .ex_src_a     (ex_src_a),
        .ex_src_b     (ex_src_b),
        .ex_illegal   (ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
        id_valid    = v;
        id_instr    = instr;
        id_pc       = pc;
        id_rs1_data = rs1;
        id_rs2_data = rs2;
        id_imm      = imm;
    endtask

    task automatic test_reset();
        logic [69:0] exp;
        // Assert reset between edges: outputs must clear without a clock edge.
        #2;
        reset = 1'b1;
        #1;
        exp = BUBBLE;
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL reset_async: got %h want %h", obs, exp);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL reset_idle: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_sub();
        logic [69:0] exp;
        set_id(1'b1, 32'h40B50533, 32'h100, 32'd7, 32'd3, 32'h0);
        #1;
        // Inputs changed, no edge yet: still the bubble.
        exp = BUBBLE;
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL sub_no_comb_path: got %h want %h", obs, exp);
        end
        tick();
        exp = {1'b1, 4'b0011, 32'd7, 32'd3, 1'b0};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL sub: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_shifts();
        logic [69:0] exp;
        set_id(1'b1, 32'h40335293, 32'h104, 32'h80000000, 32'h55, 32'h403);
        tick();
        exp = {1'b1, 4'b0111, 32'h80000000, 32'h403, 1'b0};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL srai: got %h want %h", obs, exp);
        end
        set_id(1'b1, 32'h00335293, 32'h108, 32'h80000000, 32'h55, 32'h3);
        tick();
        exp = {1'b1, 4'b0101, 32'h80000000, 32'h3, 1'b0};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL srli: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_lui_branch();
        logic [69:0] exp;
        set_id(1'b1, 32'h123450B7, 32'h10C, 32'hAAAA, 32'hBBBB, 32'h12345000);
        tick();
        exp = {1'b1, 4'b0010, 32'h0, 32'h12345000, 1'b0};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL lui: got %h want %h", obs, exp);
        end
        // bne x1, x2, 8
        set_id(1'b1, 32'h00209463, 32'h110, 32'h11, 32'h22, 32'h8);
        tick();
        exp = {1'b1, 4'b1000, 32'h11, 32'h22, 1'b0};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL bne: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_pc_ops();
        logic [69:0] exp;
        // jal x0, 0 : link address pc + 4
        set_id(1'b1, 32'h0000006F, 32'h200, 32'h1, 32'h2, 32'h40);
        tick();
        exp = {1'b1, 4'b0010, 32'h200, 32'h4, 1'b0};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL jal: got %h want %h", obs, exp);
        end
        // auipc x0, 0
        set_id(1'b1, 32'h00000017, 32'h204, 32'h1, 32'h2, 32'h7000);
        tick();
        exp = {1'b1, 4'b0010, 32'h204, 32'h7000, 1'b0};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL auipc: got %h want %h", obs, exp);
        end
        // sltu x10, x10, x11 : unsupported, operands still rs1/rs2
        set_id(1'b1, 32'h00B53533, 32'h208, 32'h5, 32'h6, 32'h0);
        tick();
        exp = {1'b1, 4'b1111, 32'h5, 32'h6, 1'b1};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL sltu: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_stall_flush();
        logic [69:0] exp;
        // add x10, x10, x11
        set_id(1'b1, 32'h00B50533, 32'h300, 32'd10, 32'd20, 32'h0);
        tick();
        exp = {1'b1, 4'b0010, 32'd10, 32'd20, 1'b0};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL stall_load_add: got %h want %h", obs, exp);
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 32'h40B50533, 32'h304 + i, 32'd100 + i, 32'd1, 32'h0);
            tick();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL stall_hold_%0d: got %h want %h", i, obs, exp);
            end
        end
        flush = 1'b1;
        tick();
        exp = BUBBLE;
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL stall_flush_together: got %h want %h", obs, exp);
        end
        flush = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        logic [69:0] exp;
        set_id(1'b1, 32'h40B50533, 32'h400, 32'd9, 32'd4, 32'h0);
        tick();
        stall = 1'b1;
        tick();
        #2;
        reset = 1'b1;
        #1;
        exp = BUBBLE;
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL reset_in_stall: got %h want %h", obs, exp);
        end
        tick();
        reset = 1'b0;
        tick();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL reset_release_stalled: got %h want %h", obs, exp);
        end
        stall = 1'b0;
        tick();
        exp = {1'b1, 4'b0011, 32'd9, 32'd4, 1'b0};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL reset_then_load: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_illegal();
        logic [69:0] exp;
        set_id(1'b1, 32'h0000000B, 32'h500, 32'h77, 32'h88, 32'h99);
        tick();
        exp = {1'b1, 4'b1111, 32'h0, 32'h0, 1'b1};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL illegal_opcode: got %h want %h", obs, exp);
        end
        set_id(1'b0, 32'h0000000B, 32'h500, 32'h77, 32'h88, 32'h99);
        tick();
        exp = BUBBLE;
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL invalid_is_bubble: got %h want %h", obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        set_id(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        test_reset();
        test_sub();
        test_shifts();
        test_lui_branch();
        test_pc_ops();
        test_stall_flush();
        test_reset_mid_stall();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_alu_ctrl.md
# id_ex_alu_ctrl

ID/EX pipeline stage that produces the ALU's control and operand inputs. It decodes the instruction's opcode, funct3 and funct7 into the 4-bit ALU operation code, and it selects the SrcA and SrcB operands. The result is registered into the ID/EX boundary, which has stall and flush control. The registered outputs drive the EX-stage ALU directly.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/PC/immediate width
- OPCODE_LENGTH, 4, ALU operation code width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_instr  in  32  raw instruction word
- id_pc  in  DATA_WIDTH  instruction PC
- id_rs1_data  in  DATA_WIDTH  rs1 value (already forwarded)
- id_rs2_data  in  DATA_WIDTH  rs2 value (already forwarded)
- id_imm  in  DATA_WIDTH  sign-extended immediate from the immediate generator
- stall  in  1  hold the ID/EX register
- flush  in  1  replace the ID/EX contents with a bubble
- ex_valid  out  1  EX holds a real instruction
- ex_operation  out  OPCODE_LENGTH  ALU Operation code
- ex_src_a  out  DATA_WIDTH  ALU SrcA
- ex_src_b  out  DATA_WIDTH  ALU SrcB
- ex_illegal  out  1  decoded encoding is unsupported

## Operation
ALU operation codes:
- AND 0000, OR 0001, ADD 0010, SUB 0011
- SLL 0100, SRL 0101, SRA 0111
- XOR 1010, EQ 1000, SLT 1100
- NOP_ILL 1111 (the ALU returns 0 for this code)

Decode rules:
- R-type (0110011), by funct3:
  - 000: ADD, or SUB if funct7[5]
  - 001: SLL; 010: SLT; 100: XOR
  - 101: SRL, or SRA if funct7[5]
  - 110: OR; 111: AND
  - 011 (SLTU): NOP_ILL with ex_illegal=1
  - SrcA=rs1, SrcB=rs2
- I-ALU (0010011):
  - Same funct3 map as R-type, except 000 is always ADD.
  - 101 uses funct7[5] to choose SRAI.
  - 011 is illegal.
  - SrcA=rs1, SrcB=imm
- Load (0000011) and store (0100011): ADD, SrcA=rs1, SrcB=imm.
- Branch (1100011):
  - BEQ and BNE: EQ. BLT and BGE: SLT.
  - The branch unit applies the inversion.
  - 110 and 111 are illegal.
  - SrcA=rs1, SrcB=rs2
- LUI (0110111): ADD, SrcA=0, SrcB=imm.
- AUIPC (0010111): ADD, SrcA=pc, SrcB=imm.
- JAL (1101111) and JALR (1100111): ADD, SrcA=pc, SrcB=4 (link address).
- Any other opcode: NOP_ILL, ex_illegal=1, both sources 0.
- id_valid=0 decodes as a bubble.
- Bubble definition: ex_valid=0, ex_operation=ADD, ex_src_a=0, ex_src_b=0, ex_illegal=0.
- ex_illegal is qualified by ex_valid. The block does not raise exceptions itself.

## Timing
- Reset (asynchronous, takes effect immediately): every output is the bubble value (ex_valid=0, ex_operation=0010, sources 0, ex_illegal=0).
- Latency is 1 cycle: the ID inputs sampled at edge N appear on the ex_* outputs after edge N.
- Register update priority per edge:
  1. flush loads a bubble.
  2. Otherwise stall holds every ex_* output unchanged.
  3. Otherwise the register loads the decoded ID values.
- flush and stall asserted together: flush wins.
- Stall lasting several cycles: the outputs stay stable and the ID inputs are ignored.
- Reset in the middle of a stall: the register is cleared, and after reset release it loads on the next edge that has no stall.
- No combinational path from any input to any output.

## Structure
- Package alu_pkg holds:
  - alu_op_t, a 4-bit enum containing every code above
  - localparams for the RISC-V opcodes
  - the bubble constant
- Sub-module alu_op_decoder: purely combinational. It maps instr/pc/rs1/rs2/imm to {op, src_a, src_b, illegal}.
- The top level holds only the ID/EX register and its stall/flush priority.

## Test plan
- Reset with outputs garbage → all outputs become the bubble value while reset is high, with no clock edge needed.
- id_instr=0x40B50533 (sub), rs1=7, rs2=3 → one edge later: op=0011, src_a=7, src_b=3, ex_valid=1.
- id_instr=0x40335293 (srai), rs1=0x80000000, imm=0x403 → op=0111, src_b=0x403. A second instruction, 0x00335293 (srli), gives op=0101.
- id_instr=0x123450B7 (lui), imm=0x12345000 → op=0010, src_a=0, src_b=0x12345000. A BNE instruction (funct3 001) gives op=1000, src_b=rs2.
- Load an ADD, then hold stall for 3 cycles while the inputs change → outputs frozen. Then stall=1 and flush=1 together → bubble on the next edge.
- id_instr with opcode 0001011 → op=1111, ex_illegal=1, ex_valid=1. The same input with id_valid=0 → bubble with ex_illegal=0.
